// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_buffer
// Description : MIPS fetch stage. Holds the fetch PC, drives the instruction
//               RAM address and queues each returned word with its PC in a
//               small FIFO. The FIFO feeds decode over a valid/ready
//               handshake. Branch/jump redirects flush the queue. A redirect
//               to HALT_ADDR stops fetching until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int          DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              instr_address,
  input  logic [31:0]              instr_readdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     active,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              active_q, active_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       pc_mem_d    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];

  logic              is_run;
  logic              not_empty;
  logic              pop;
  logic              push;
  logic              take_redirect;
  logic [31:0]       aligned_pc;

  // Next-state logic: redirect flushes and wins over push/pop; otherwise the
  // FIFO pushes the current RAM word and pops the head as the handshake allows.
  always_comb begin
    is_run        = (state_q == ST_RUN);
    not_empty     = (count_q != '0);
    pop           = not_empty & out_ready;
    take_redirect = is_run & redirect_valid;
    // A full FIFO can still accept a word when the head leaves this cycle.
    push          = is_run & ~redirect_valid & ((count_q != C_DEPTH_CNT) | pop);
    aligned_pc    = {redirect_pc[31:2], 2'b00};

    state_d     = state_q;
    active_d    = active_q;
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (take_redirect) begin
      // Any pop offered alongside the redirect is dropped with the flush.
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = aligned_pc;
      if (aligned_pc == HALT_ADDR) begin
        state_d  = ST_HALTED;
        active_d = 1'b0;
      end
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = fetch_pc_q;
        instr_mem_d[tail_q] = instr_readdata;
        tail_d              = tail_q + PTR_W'(1);
        // Wraps modulo 2^32; address 0 reached this way is not a halt.
        fetch_pc_d          = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers, cleared asynchronously so reset empties the FIFO at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      active_q   <= 1'b1;
      fetch_pc_q <= RESET_VECTOR;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  // Output drive: head fields are forced to zero while the FIFO is empty.
  always_comb begin
    instr_address = fetch_pc_q;
    out_valid     = (count_q != '0);
    out_instr     = out_valid ? instr_mem_q[head_q] : 32'h0;
    out_pc        = out_valid ? pc_mem_q[head_q]    : 32'h0;
    active        = active_q;
    occupancy     = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_buffer
// Description : Self-checking bench for instr_fetch_buffer. A table of
//               per-cycle vectors covers fill, full-with-pop, redirect and
//               halt entry; hand-written sequences cover halt persistence,
//               PC wrap and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buffer;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        active;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_buffer #(
    .RESET_VECTOR (32'hBFC00000),
    .HALT_ADDR    (32'h00000000),
    .DEPTH        (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .active         (active),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Instruction RAM model: each word is a fixed scramble of its address.
  function automatic logic [31:0] ram(input logic [31:0] a);
    return a ^ 32'h5EED1234;
  endfunction

  assign instr_readdata = ram(instr_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against an expected snapshot.
  task automatic chk_all(input string tag, input logic v, input logic [31:0] pc,
                         input logic [2:0] occ, input logic [31:0] addr, input logic act);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_pc"}, out_pc, pc);
    chk({tag, ".out_instr"}, out_instr, v ? ram(pc) : 32'h0);
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    chk({tag, ".instr_address"}, instr_address, addr);
    chk({tag, ".active"}, 32'(active), 32'(act));
  endtask

  // Hold reset over one rising edge, release it on a falling edge.
  task automatic do_reset();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    reset          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [2:0]  occ;
    logic [31:0] addr;
    logic        act;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Row N: inputs applied in cycle N, outputs expected during cycle N.
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0, RV,            1'b1};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, RV,            3'd1, RV + 32'h4,    1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, RV,            3'd2, RV + 32'h8,    1'b1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, RV,            3'd3, RV + 32'hC,    1'b1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, RV,            3'd4, RV + 32'h10,   1'b1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, RV,            3'd4, RV + 32'h10,   1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, RV,            3'd4, RV + 32'h10,   1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, RV + 32'h4,    3'd4, RV + 32'h14,   1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, RV + 32'h8,    3'd4, RV + 32'h18,   1'b1};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, RV + 32'hC,    3'd4, RV + 32'h1C,   1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'hBFC00103,  1'b1, RV + 32'hC,    3'd4, RV + 32'h1C,   1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0, 32'hBFC00100,  1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC00100,  3'd1, 32'hBFC00104,  1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC00104,  3'd1, 32'hBFC00108,  1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'h00000002,  1'b1, 32'hBFC00108,  3'd1, 32'hBFC0010C,  1'b1};
    tbl[15] = '{1'b1, 1'b1, RV,            1'b0, 32'h0,         3'd0, 32'h0,         1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0, 32'h0,         1'b0};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      out_ready      = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc, tbl[i].occ, tbl[i].addr, tbl[i].act);
      @(negedge clk);
    end

    // Halted: redirects and out_ready have no effect for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      out_ready      = 1'b1;
      redirect_valid = i[0];
      redirect_pc    = RV;
      #1;
      chk_all($sformatf("halt%0d", i), 1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
      @(negedge clk);
    end

    // Reset leaves the halted state immediately.
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_all("halt_reset", 1'b0, 32'h0, 3'd0, RV, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // PC wrap across 2^32: address 0 reached by increment does not halt.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk_all("wrap0", 1'b0, 32'h0, 3'd0, 32'hFFFFFFF8, 1'b1);
    @(negedge clk);
    chk_all("wrap1", 1'b1, 32'hFFFFFFF8, 3'd1, 32'hFFFFFFFC, 1'b1);
    @(negedge clk);
    chk_all("wrap2", 1'b1, 32'hFFFFFFF8, 3'd2, 32'h00000000, 1'b1);
    @(negedge clk);
    chk_all("wrap3", 1'b1, 32'hFFFFFFF8, 3'd3, 32'h00000004, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk_all("wrap4", 1'b1, 32'hFFFFFFFC, 3'd3, 32'h00000008, 1'b1);
    @(negedge clk);
    chk_all("wrap5", 1'b1, 32'h00000000, 3'd3, 32'h0000000C, 1'b1);

    // Asynchronous reset with two entries queued, checked before the next edge.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all("pre_async", 1'b1, RV, 3'd2, RV + 32'h8, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 3'd0, RV, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
